// File: rtl/masked_sbox_layer_ctrl.sv
// Sequencer for one PRESENT substitution layer on a 3-share masked state.
// Issues the nibbles one per cycle into a shared pipelined masked S-box.
// An issue needs fresh randomness. A tag pipe that matches the S-box latency
// tells which nibble slot each returning result belongs to.
module masked_sbox_layer_ctrl #(
  parameter int NIB   = 16,
  parameter int LAT   = 5,
  parameter int RND_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] state_in1,
  input  logic [4*NIB-1:0] state_in2,
  input  logic [4*NIB-1:0] state_in3,
  input  logic             rnd_valid,
  input  logic [RND_W-1:0] rnd_in,
  output logic             rnd_ready,
  output logic [3:0]       sb_in1,
  output logic [3:0]       sb_in2,
  output logic [3:0]       sb_in3,
  output logic [RND_W-1:0] sb_r,
  input  logic [3:0]       sb_out1,
  input  logic [3:0]       sb_out2,
  input  logic [3:0]       sb_out3,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] state_out1,
  output logic [4*NIB-1:0] state_out2,
  output logic [4*NIB-1:0] state_out3
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SW = 4 * NIB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [SW-1:0]   work1_reg, work2_reg, work3_reg;
  logic [SW-1:0]   state_out1_reg, state_out2_reg, state_out3_reg;
  logic [LAT-1:0]  tag_vld_reg;
  logic [IW-1:0]   tag_idx_reg [LAT];
  logic            issue;
  logic            pending;
  logic [NIB-1:0]  cap_hit;

  // Decode which nibble slot the result leaving the S-box pipe lands in.
  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_cap
      assign cap_hit[gi] = tag_vld_reg[LAT-1] && (tag_idx_reg[LAT-1] == IW'(gi));
    end
  endgenerate

  // Next state, and the issue handshake.
  // Shares reach the S-box only during an accepted issue.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    issue      = 1'b0;
    rnd_ready  = 1'b0;
    sb_in1     = 4'h0;
    sb_in2     = 4'h0;
    sb_in3     = 4'h0;
    sb_r       = '0;
    // Results still in flight after this edge. The stage leaving the pipe
    // is captured at this edge, so it does not count.
    pending    = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pending = pending | tag_vld_reg[i];
    end
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_ISSUE;
          idx_next   = '0;
        end
      end
      S_ISSUE: begin
        if (rnd_valid) begin
          issue     = 1'b1;
          rnd_ready = 1'b1;
          sb_in1    = work1_reg[{idx_reg, 2'b00} +: 4];
          sb_in2    = work2_reg[{idx_reg, 2'b00} +: 4];
          sb_in3    = work3_reg[{idx_reg, 2'b00} +: 4];
          sb_r      = rnd_in;
          idx_next  = idx_reg + IW'(1);
          if (idx_reg == IW'(NIB - 1)) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM state, the issue index, and the input working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      work1_reg <= '0;
      work2_reg <= '0;
      work3_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (state_reg == S_IDLE && start) begin
        work1_reg <= state_in1;
        work2_reg <= state_in2;
        work3_reg <= state_in3;
      end
    end
  end

  // Tag pipe. It shifts every cycle so that it stays in step with the S-box.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_reg <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_idx_reg[i] <= '0;
      end
    end else begin
      tag_vld_reg[0] <= issue;
      tag_idx_reg[0] <= idx_reg;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_reg[i] <= tag_vld_reg[i-1];
        tag_idx_reg[i] <= tag_idx_reg[i-1];
      end
    end
  end

  // Write each returning result, share by share, into its own nibble slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out1_reg <= '0;
      state_out2_reg <= '0;
      state_out3_reg <= '0;
    end else begin
      for (int i = 0; i < NIB; i++) begin
        if (cap_hit[i]) begin
          state_out1_reg[4*i +: 4] <= sb_out1;
          state_out2_reg[4*i +: 4] <= sb_out2;
          state_out3_reg[4*i +: 4] <= sb_out3;
        end
      end
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign state_out1 = state_out1_reg;
  assign state_out2 = state_out2_reg;
  assign state_out3 = state_out3_reg;

endmodule
